main: RTL and testbench

- Pipelined fused multiply-add: y = a*b + c, with a and b signed.
- Structured to map onto a single DSP slice: input registers, then a multiply-accumulate output register.
- Sits as a leaf datapath block.
- A global clock enable stalls the entire pipeline.

---
 rtl/main_pkg.sv | 16 +
 rtl/main_pipe_reg.sv | 27 ++
 rtl/main.sv | 63 ++++++
 tb/tb_main.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/main_pkg.sv
// Shared widths and operand types for the fused multiply-add datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a; the datapath stalls only through its global enable.
package main_pkg;

  localparam int AW = 8;   // multiplicand width (signed)
  localparam int BW = 8;   // multiplier width (signed)
  localparam int CW = 16;  // addend width (two's complement)
  localparam int YW = 16;  // result width; equals CW and covers AW+BW

  typedef logic signed [AW-1:0] a_t;
  typedef logic signed [BW-1:0] b_t;
  typedef logic signed [CW-1:0] c_t;
  typedef logic signed [YW-1:0] y_t;

endpackage

// File: rtl/main_pipe_reg.sv
// Generic pipeline register with synchronous active-high clear and clock enable.
// Latency: 1 enabled clock edge.
// Backpressure: en_i=0 holds the stored value; reset clears regardless of en_i.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Reset wins over enable; otherwise capture only on enabled edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/main.sv
// Pipelined fused multiply-add y = a*b + c, shaped for a single DSP slice.
// Latency: 2 enabled clock edges from a/b/c to y.
// Backpressure: en=0 freezes every stage, including y; nothing is dropped.
module main
  import main_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  a_t   a,
  input  b_t   b,
  input  c_t   c,
  input  logic en,
  output y_t   y
);

  a_t a1_q;
  b_t b1_q;
  c_t c1_q;
  y_t y_d;
  y_t y_q;

  // Stage 1: DSP input registers.
  pipe_reg #(.W(AW)) u_a1 (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (en),
    .d_i   (a),
    .q_o   (a1_q)
  );

  pipe_reg #(.W(BW)) u_b1 (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (en),
    .d_i   (b),
    .q_o   (b1_q)
  );

  pipe_reg #(.W(CW)) u_c1 (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (en),
    .d_i   (c),
    .q_o   (c1_q)
  );

  // Multiply-add in YW bits: operands sign-extended, product and sum wrap mod 2^YW.
  always_comb begin
    y_d = y_t'(a1_q) * y_t'(b1_q) + c1_q;
  end

  // Stage 2: multiply-accumulate output register; y comes straight from it.
  pipe_reg #(.W(YW)) u_y (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (en),
    .d_i   (y_d),
    .q_o   (y_q)
  );

  assign y = y_q;

endmodule

// File: tb/tb_main.sv
// Self-checking bench for the pipelined multiply-add: directed vectors,
// a queue-based reference model checked every cycle, plus literal pins.
module tb_main;

  logic               clock;
  logic               reset;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic signed [15:0] c;
  logic               en;
  logic signed [15:0] y;

  int vectors = 0;
  int errors  = 0;

  main dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .en    (en),
    .y     (y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference arithmetic: integer a*b + c, keep the low 16 bits.
  function automatic logic [15:0] fma(input int fa, input int fb, input int fc);
    int r;
    r = fa * fb + fc;
    return r[15:0];
  endfunction

  // Model: results of inputs accepted on enabled edges since the last reset.
  // y shows the result accepted one enabled edge before the most recent one.
  logic [15:0] hist[$];
  logic [15:0] exp_y = 16'h0;
  bit          model_on = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      hist.delete();
      model_on = 1'b1;
    end else if (en) begin
      hist.push_back(fma(int'(a), int'(b), int'(c)));
      if (hist.size() > 2) void'(hist.pop_front());
    end
    exp_y = (hist.size() >= 2) ? hist[hist.size()-2] : 16'h0;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_on) begin
      vectors++;
      if (y !== exp_y) begin
        errors++;
        $display("FAIL model_cmp t=%0t: y=%h expected %h", $time, y, exp_y);
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] expv);
    vectors++;
    if (y !== expv) begin
      errors++;
      $display("FAIL %s: y=%h expected %h", nm, y, expv);
    end
  endtask

  // Drive one set of inputs, then advance one rising edge and settle.
  task automatic step(input int na, input int nb, input int nc,
                      input logic nen, input logic nrst);
    a     = 8'(na);
    b     = 8'(nb);
    c     = 16'(nc);
    en    = nen;
    reset = nrst;
    @(posedge clock);
    #1;
  endtask

  int sa[8] = '{ 1,  -2,  10, 127,  -7,  33, -128,  5};
  int sb[8] = '{ 1,   3,  -4,   2,  -7,  -1,    1, 20};
  int sc[8] = '{ 0, 100,   5,  -1, 200,   0,  -50,  9};

  initial begin
    a = '0; b = '0; c = '0; en = 1'b0; reset = 1'b1;

    // Reset with en low clears everything.
    step(0, 0, 0, 1'b0, 1'b1);
    step(0, 0, 0, 1'b0, 1'b1);
    check("reset_state", 16'h0000);

    // Steady state 8*2+3: zero after first enabled edge, 19 from the second on.
    step(8, 2, 3, 1'b1, 1'b0);
    check("steady_edge1", 16'h0000);
    step(8, 2, 3, 1'b1, 1'b0);
    check("steady_edge2", 16'd19);
    for (int i = 0; i < 2000; i++) step(8, 2, 3, 1'b1, 1'b0);
    check("steady_long", 16'd19);

    // Signed operands.
    step(-3, 5, 0, 1'b1, 1'b0);
    check("signed_neg_lag", 16'd19);
    step(-3, 5, 0, 1'b1, 1'b0);
    check("signed_neg", 16'hFFF1);
    step(-128, -128, 1, 1'b1, 1'b0);
    step(-128, -128, 1, 1'b1, 1'b0);
    check("signed_min", 16'd16385);

    // Wrap-around: 16129 + 32767 = 48896 = 0xBF00 modulo 2^16.
    step(127, 127, 32'h7FFF, 1'b1, 1'b0);
    step(127, 127, 32'h7FFF, 1'b1, 1'b0);
    check("wrap", 16'hBF00);

    // Streaming sequence with a 3-cycle stall mid-stream; garbage during stall.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int k = 0; k < 3; k++) step(99, 99, 999, 1'b0, 1'b0);
        check("stall_frozen", fma(sa[2], sb[2], sc[2]));
      end
      step(sa[i], sb[i], sc[i], 1'b1, 1'b0);
    end
    check("stream_tail_m1", fma(sa[6], sb[6], sc[6]));
    step(0, 0, 0, 1'b1, 1'b0);
    check("stream_tail", fma(sa[7], sb[7], sc[7]));

    // Reset mid-stream with en low, then refill.
    step(11, 12, 13, 1'b1, 1'b0);
    step(3, 3, 3, 1'b0, 1'b1);
    check("rst_en0", 16'h0000);
    step(5, 6, 7, 1'b1, 1'b0);
    check("refill_edge1", 16'h0000);
    step(5, 6, 7, 1'b1, 1'b0);
    check("refill_edge2", 16'd37);

    // Reset mid-stream with en high, then refill.
    step(9, 9, 9, 1'b1, 1'b0);
    step(9, 9, 9, 1'b1, 1'b1);
    check("rst_en1", 16'h0000);
    step(-4, 3, 10, 1'b1, 1'b0);
    check("refill2_edge1", 16'h0000);
    step(-4, 3, 10, 1'b1, 1'b0);
    check("refill2_edge2", 16'hFFFE);
    step(-4, 3, 10, 1'b1, 1'b0);

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
